// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multi-cycle multiply/divide unit:
//   - ALU control codes that select a multiply or divide operation
//   - FSM state encoding
//   - iteration counter width helper
//   - helper that recognises a valid multiply/divide control code
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam logic [4:0] ALU_MULT  = 5'b10100;
  localparam logic [4:0] ALU_MULTU = 5'b10011;
  localparam logic [4:0] ALU_DIV   = 5'b10101;
  localparam logic [4:0] ALU_DIVU  = 5'b10110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // The counter must be able to hold the value WIDTH itself, hence the +1.
  function automatic int mdu_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic logic is_mdu_op(input logic [4:0] code);
    return (code == ALU_MULT) || (code == ALU_MULTU) ||
           (code == ALU_DIV)  || (code == ALU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// -----------------------------------------------------------------------------
// mdu_sign_fix
// Combinational result correction applied when the unit leaves its iteration
// phase. The iteration datapath always works on magnitudes; this block turns
// the raw magnitude result into the architectural HI/LO values.
//
// Ports:
//   i_is_div     1      operation is a divide (else multiply)
//   i_neg_res    1      negate product (multiply) or quotient (divide)
//   i_neg_rem    1      negate remainder (divide only, dividend was negative)
//   i_div_zero   1      divisor was zero: override with all-ones / dividend
//   i_dividend   WIDTH  dividend as originally latched (divide-by-zero HI)
//   i_raw_hi     WIDTH  product upper half, or remainder magnitude
//   i_raw_lo     WIDTH  product lower half, or quotient magnitude
//   o_hi         WIDTH  corrected HI value
//   o_lo         WIDTH  corrected LO value
// -----------------------------------------------------------------------------
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic             i_neg_res,
  input  logic             i_neg_rem,
  input  logic             i_div_zero,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_raw_hi,
  input  logic [WIDTH-1:0] i_raw_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_neg;

  assign w_prod     = {i_raw_hi, i_raw_lo};
  assign w_prod_neg = -w_prod;

  always_comb begin
    o_hi = i_raw_hi;
    o_lo = i_raw_lo;
    if (!i_is_div) begin
      // Product sign correction spans the full double-width value.
      if (i_neg_res) begin
        o_hi = w_prod_neg[2*WIDTH-1:WIDTH];
        o_lo = w_prod_neg[WIDTH-1:0];
      end
    end else if (i_div_zero) begin
      o_lo = '1;
      o_hi = i_dividend;
    end else begin
      // Most-negative / -1 needs no special case: the quotient magnitude is
      // 2^(WIDTH-1) and negating it yields the same bit pattern.
      o_lo = i_neg_res ? -i_raw_lo : i_raw_lo;
      o_hi = i_neg_rem ? -i_raw_hi : i_raw_hi;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// A start with a valid ALU control code is accepted while idle; the unit then
// runs WIDTH radix-2 iterations (shift-add multiply or restoring divide on
// operand magnitudes), spends one cycle applying sign correction, writes
// HI/LO and pulses done. busy is high for the RUN and FIX phases.
//
// Optional build macro: MDU_EARLY_OUT_EN
//   When defined, multiplies leave RUN as soon as the remaining multiplier
//   bits are all zero (at least one iteration); the partial product is then
//   aligned by the number of skipped shifts. Divide timing is unaffected.
//
// Handshake: start is a request level sampled only on edges where the unit
// is idle (including the done cycle); there is no backpressure, the caller
// observes busy/done. hi_we/lo_we write wdata on idle edges only.
//
// Ports:
//   clk         1      clock, rising edge
//   reset_n     1      asynchronous active-low reset
//   start       1      operation request
//   alucontrol  5      operation code (MULT/MULTU/DIV/DIVU)
//   srca        WIDTH  dividend / multiplicand
//   srcb        WIDTH  divisor / multiplier
//   hi_we       1      HI write enable (mthi)
//   lo_we       1      LO write enable (mtlo)
//   wdata       WIDTH  mthi/mtlo data
//   busy        1      operation in progress
//   done        1      one-cycle pulse when HI/LO take a result
//   hi          WIDTH  HI register
//   lo          WIDTH  LO register
//   dbg_state   2      current FSM state (mdu_state_e encoding)
// -----------------------------------------------------------------------------
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = mdu_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  // FSM
  mdu_state_e r_state;
  mdu_state_e w_next_state;
  logic       w_busy;
  logic       w_last_iter;

  // Latched operation context
  logic             r_is_div;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_srca;
  logic [CW-1:0]    r_cnt;

  // Iteration registers: multiply uses {r_acc_hi, r_acc_lo} as the product
  // register with the multiplier shifting out of r_acc_lo; divide uses
  // r_acc_hi as the partial remainder and r_acc_lo as dividend/quotient.
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_opb;

  // Architectural results
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  // Decode of the incoming request
  logic             w_start_ok;
  logic             w_in_div;
  logic             w_in_signed;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  // One iteration of each datapath
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi_nxt;
  logic [WIDTH-1:0] w_mul_lo_nxt;
  logic [WIDTH:0]   w_div_trial;
  logic [WIDTH-1:0] w_div_sub;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_hi_nxt;
  logic [WIDTH-1:0] w_div_lo_nxt;

  // Sign correction inputs/outputs
  logic [WIDTH-1:0] w_raw_hi;
  logic [WIDTH-1:0] w_raw_lo;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_start_ok  = start && is_mdu_op(alucontrol);
  assign w_in_div    = (alucontrol == ALU_DIV) || (alucontrol == ALU_DIVU);
  assign w_in_signed = (alucontrol == ALU_MULT) || (alucontrol == ALU_DIV);
  assign w_abs_a     = (w_in_signed && srca[WIDTH-1]) ? -srca : srca;
  assign w_abs_b     = (w_in_signed && srcb[WIDTH-1]) ? -srcb : srcb;

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole product register right.
  assign w_mul_sum = {1'b0, r_acc_hi} + {1'b0, r_opb};

  always_comb begin
    w_mul_hi_nxt = {1'b0, r_acc_hi[WIDTH-1:1]};
    w_mul_lo_nxt = {r_acc_hi[0], r_acc_lo[WIDTH-1:1]};
    if (r_acc_lo[0]) begin
      w_mul_hi_nxt = w_mul_sum[WIDTH:1];
      w_mul_lo_nxt = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
    end
  end

  // Restoring divide: bring in the next dividend bit, subtract the divisor
  // if it fits. The trial value is below 2*divisor, so when it fits the
  // difference is below the divisor and modulo-2^WIDTH subtraction is exact.
  assign w_div_trial  = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_ge     = (w_div_trial >= {1'b0, r_opb});
  assign w_div_sub    = w_div_trial[WIDTH-1:0] - r_opb;
  assign w_div_hi_nxt = w_div_ge ? w_div_sub : w_div_trial[WIDTH-1:0];
  assign w_div_lo_nxt = {r_acc_lo[WIDTH-2:0], w_div_ge};

`ifdef MDU_EARLY_OUT_EN
  logic [WIDTH-1:0]   r_mrem;
  logic [WIDTH-1:0]   w_mrem_nxt;
  logic [CW-1:0]      w_shift;
  logic [2*WIDTH-1:0] w_prod_aligned;

  // Multiplier bits that are still to be consumed after this iteration.
  assign w_mrem_nxt     = r_mrem >> 1;
  assign w_last_iter    = (r_cnt == LAST_ITER) ||
                          (!r_is_div && (w_mrem_nxt == '0));
  // Skipped iterations would each have shifted the product right once more.
  assign w_shift        = CW'(WIDTH) - r_cnt;
  assign w_prod_aligned = {r_acc_hi, r_acc_lo} >> w_shift;
  assign w_raw_hi       = r_is_div ? r_acc_hi : w_prod_aligned[2*WIDTH-1:WIDTH];
  assign w_raw_lo       = r_is_div ? r_acc_lo : w_prod_aligned[WIDTH-1:0];
`else
  assign w_last_iter = (r_cnt == LAST_ITER);
  assign w_raw_hi    = r_acc_hi;
  assign w_raw_lo    = r_acc_lo;
`endif

  mdu_sign_fix #(
    .WIDTH(WIDTH)
  ) u_sign_fix (
    .i_is_div   (r_is_div),
    .i_neg_res  (r_neg_res),
    .i_neg_rem  (r_neg_rem),
    .i_div_zero (r_div_zero),
    .i_dividend (r_srca),
    .i_raw_hi   (w_raw_hi),
    .i_raw_lo   (w_raw_lo),
    .o_hi       (w_fix_hi),
    .o_lo       (w_fix_lo)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and busy
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last_iter) begin
          w_next_state = ST_FIX;
        end
      end
      ST_FIX: begin
        w_busy       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath and HI/LO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      r_srca     <= '0;
      r_cnt      <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_opb      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
`ifdef MDU_EARLY_OUT_EN
      r_mrem     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (w_start_ok) begin
            r_is_div   <= w_in_div;
            r_neg_res  <= w_in_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            r_neg_rem  <= w_in_signed && srca[WIDTH-1];
            r_div_zero <= w_in_div && (srcb == '0);
            r_srca     <= srca;
            r_cnt      <= '0;
            r_acc_hi   <= '0;
            // Multiply: multiplier in the low half, multiplicand aside.
            // Divide: dividend in the low half, divisor aside.
            r_acc_lo   <= w_in_div ? w_abs_a : w_abs_b;
            r_opb      <= w_in_div ? w_abs_b : w_abs_a;
`ifdef MDU_EARLY_OUT_EN
            r_mrem     <= w_abs_b;
`endif
          end
        end
        ST_RUN: begin
          r_cnt    <= r_cnt + 1'b1;
          r_acc_hi <= r_is_div ? w_div_hi_nxt : w_mul_hi_nxt;
          r_acc_lo <= r_is_div ? w_div_lo_nxt : w_mul_lo_nxt;
`ifdef MDU_EARLY_OUT_EN
          r_mrem   <= w_mrem_nxt;
`endif
        end
        ST_FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = w_busy;
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mdu_unit.sv
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int W = 32;

`ifdef MDU_EARLY_OUT_EN
  localparam int CYC_MULT_NEG = 4;   // -3 x 5: multiplier 5 needs 3 iterations
  localparam int CYC_7X1      = 2;
  localparam int CYC_2X3      = 3;
`else
  localparam int CYC_MULT_NEG = 33;
  localparam int CYC_7X1      = 33;
  localparam int CYC_2X3      = 33;
`endif

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [4:0]   alucontrol;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   dbg_state;

  int checks;
  int errors;

  mdu_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge, then scrambles the operands so any
  // dependence on them after the accepting edge shows up in the result.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start      = 1'b1;
    alucontrol = op;
    srca       = a;
    srcb       = b;
    tick();
    start      = 1'b0;
    alucontrol = 5'b00000;
    srca       = $urandom;
    srcb       = $urandom;
  endtask

  // Counts busy samples until the unit is idle again; bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_multu_max();
    int n;
    issue(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL multu_max_cycles: got %0d expected 33", n); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL multu_max_done: got %b expected 1", done); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_max_hi: got %h expected fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_max_lo: got %h expected 00000001", lo); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_mult_signed();
    int n;
    issue(ALU_MULT, 32'hFFFFFFFD, 32'd5);
    wait_done(n);
    checks++; if (n !== CYC_MULT_NEG) begin errors++; $display("FAIL mult_neg_cycles: got %0d expected %0d", n, CYC_MULT_NEG); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_neg_lo: got %h expected fffffff1", lo); end
    issue(ALU_MULTU, 32'd7, 32'd1);
    wait_done(n);
    checks++; if (n !== CYC_7X1) begin errors++; $display("FAIL multu_7x1_cycles: got %0d expected %0d", n, CYC_7X1); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL multu_7x1_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h7) begin errors++; $display("FAIL multu_7x1_lo: got %h expected 00000007", lo); end
  endtask

  task automatic test_divide();
    int n;
    issue(ALU_DIV, 32'hFFFFFFF9, 32'd2);           // -7 / 2 = -3 rem -1
    wait_done(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL div_neg_cycles: got %0d expected 33", n); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
    issue(ALU_DIV, 32'd7, 32'hFFFFFFFE);           // 7 / -2 = -3 rem 1
    wait_done(n);
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negdiv_lo: got %h expected fffffffd", lo); end
    checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL div_negdiv_hi: got %h expected 00000001", hi); end
    issue(ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
    issue(ALU_DIVU, 32'd100, 32'd7);
    wait_done(n);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
  endtask

  task automatic test_div_zero();
    int n;
    issue(ALU_DIVU, 32'd100, 32'd0);
    wait_done(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL divu0_cycles: got %0d expected 33", n); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo: got %h expected ffffffff", lo); end
    checks++; if (hi !== 32'h00000064) begin errors++; $display("FAIL divu0_hi: got %h expected 00000064", hi); end
    issue(ALU_DIV, 32'd100, 32'd0);
    wait_done(n);
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h expected ffffffff", lo); end
    checks++; if (hi !== 32'h00000064) begin errors++; $display("FAIL div0_hi: got %h expected 00000064", hi); end
  endtask

  task automatic test_invalid_code();
    issue(5'b00001, 32'd3, 32'd4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL invalid_busy: got %b expected 0", busy); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL invalid_state: got %0d expected 0", dbg_state); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL invalid_done: got %b expected 0", done); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL invalid_lo: got %h expected ffffffff", lo); end
  endtask

  task automatic test_reset_abort();
    int n;
    issue(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL abort_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL abort_lo: got %h expected 00000000", lo); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
    issue(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL abort_rerun_cycles: got %0d expected 33", n); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL abort_rerun_hi: got %h expected fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL abort_rerun_lo: got %h expected 00000001", lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    // 2 x 0x80000000 = 0x1_00000000; top multiplier bit keeps all 32 iterations.
    issue(ALU_MULTU, 32'd2, 32'h80000000);
    repeat (4) tick();
    start      = 1'b1;
    alucontrol = ALU_DIV;
    hi_we      = 1'b1;
    wdata      = 32'h00001234;
    tick();
    start      = 1'b0;
    alucontrol = 5'b00000;
    hi_we      = 1'b0;
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL busy_hi_we: got %h expected fffffffe", hi); end
    wait_done(n);
    checks++; if (n + 5 !== 33) begin errors++; $display("FAIL busy_start_cycles: got %0d expected 33", n + 5); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", done); end
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL b2b_hi: got %h expected 00000001", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL b2b_lo: got %h expected 00000000", lo); end
    // Done cycle: LO write and a new start together.
    lo_we      = 1'b1;
    wdata      = 32'h0000ABCD;
    start      = 1'b1;
    alucontrol = ALU_MULTU;
    srca       = 32'd2;
    srcb       = 32'd3;
    tick();
    lo_we      = 1'b0;
    start      = 1'b0;
    alucontrol = 5'b00000;
    srca       = $urandom;
    srcb       = $urandom;
    checks++; if (lo !== 32'h0000ABCD) begin errors++; $display("FAIL done_lo_we: got %h expected 0000abcd", lo); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_start_busy: got %b expected 1", busy); end
    wait_done(n);
    checks++; if (n !== CYC_2X3) begin errors++; $display("FAIL b2b_2x3_cycles: got %0d expected %0d", n, CYC_2X3); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL b2b_2x3_lo: got %h expected 00000006", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL b2b_2x3_hi: got %h expected 00000000", hi); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    alucontrol = 5'b00000;
    srca       = '0;
    srcb       = '0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    wdata      = '0;

    test_reset();
    test_multu_max();
    test_mult_signed();
    test_divide();
    test_div_zero();
    test_invalid_code();
    test_reset_abort();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
